// File: rtl/nstream_demux12.sv
// nstream_demux12: 1-to-2 valid/ready stream demultiplexer with an
// independent FIFO behind each output, so one stalled consumer never
// blocks the other channel.
module nstream_demux12 #(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               in_data,
  input  logic                       in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [N-1:0]               out0_data,
  output logic                       out0_valid,
  input  logic                       out0_ready,
  output logic [N-1:0]               out1_data,
  output logic                       out1_valid,
  input  logic                       out1_ready,
  output logic [$clog2(DEPTH+1)-1:0] occ0,
  output logic [$clog2(DEPTH+1)-1:0] occ1
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  logic [1:0]    full;
  logic [1:0]    valid;
  logic [1:0]    out_ready;
  logic [N-1:0]  rd_data [2];
  logic [OW-1:0] occ_v   [2];

  assign out_ready = {out1_ready, out0_ready};

  // Acceptance depends only on the selected channel being full; a pop in the
  // same cycle deliberately does not reopen it.
  assign in_ready = in_sel ? ~full[1] : ~full[0];

  assign out0_data  = rd_data[0];
  assign out1_data  = rd_data[1];
  assign out0_valid = valid[0];
  assign out1_valid = valid[1];
  assign occ0       = occ_v[0];
  assign occ1       = occ_v[1];

  genvar k;
  for (k = 0; k < 2; k++) begin : g_ch
    logic [N-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          push;
    logic          pop;

    assign push = in_valid && in_ready && (in_sel == 1'(k));
    assign pop  = (occ_q != '0) && out_ready[k];

    assign full[k]    = (occ_q == OW'(DEPTH));
    assign valid[k]   = (occ_q != '0);
    assign rd_data[k] = mem_q[rp_q];
    assign occ_v[k]   = occ_q;

    // Next-state pointers and occupancy; pointers wrap naturally since DEPTH
    // is a power of two.
    always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      occ_d = occ_q;
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end

    // State and storage registers; reset clears buffered words immediately.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wp_q  <= '0;
        rp_q  <= '0;
        occ_q <= '0;
        mem_q <= '{default: '0};
      end else begin
        if (push) mem_q[wp_q] <= in_data;
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        occ_q <= occ_d;
      end
    end
  end

endmodule

// File: tb/tb_nstream_demux12.sv
module tb_nstream_demux12;

  localparam int N     = 32;
  localparam int DEPTH = 2;
  localparam int OW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [N-1:0]  out1_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [OW-1:0] occ0;
  logic [OW-1:0] occ1;

  int vectors = 0;
  int errors  = 0;

  nstream_demux12 #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .occ0       (occ0),
    .occ1       (occ1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [N-1:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #12;
    vectors++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL rst_out0_valid got %b exp 0", out0_valid); end
    vectors++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL rst_out1_valid got %b exp 0", out1_valid); end
    vectors++; if (occ0 !== 2'd0 || occ1 !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d/%0d exp 0/0", occ0, occ1); end
    vectors++; if (out0_data !== 32'h0) begin errors++; $display("FAIL rst_out0_data got %h exp 0", out0_data); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_sel0 got %b exp 1", in_ready); end
    in_sel = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_sel1 got %b exp 1", in_ready); end
    @(posedge clk); #1 rst = 1'b0;
    // buffer words on both channels, then reset mid-cycle
    push(1'b0, 32'h55);
    push(1'b1, 32'h66);
    vectors++; if (occ0 !== 2'd1 || occ1 !== 2'd1) begin errors++; $display("FAIL pre_rst_occ got %0d/%0d exp 1/1", occ0, occ1); end
    #2 rst = 1'b1; #1;
    vectors++; if (occ0 !== 2'd0 || occ1 !== 2'd0) begin errors++; $display("FAIL async_rst_occ got %0d/%0d exp 0/0", occ0, occ1); end
    vectors++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b%b exp 00", out1_valid, out0_valid); end
    vectors++; if (out0_data !== 32'h0 || out1_data !== 32'h0) begin errors++; $display("FAIL async_rst_data got %h/%h exp 0/0", out0_data, out1_data); end
    in_sel = 1'b0; #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1 rst = 1'b0;
    push(1'b0, 32'h77);
    vectors++; if (out0_valid !== 1'b1 || out0_data !== 32'h77) begin errors++; $display("FAIL post_rst_push got %b/%h exp 1/00000077", out0_valid, out0_data); end
    out0_ready = 1'b1; tick(); out0_ready = 1'b0;
    vectors++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL post_rst_drain got %b exp 0", out0_valid); end
  endtask

  task automatic test_routing();
    out0_ready = 1'b1; out1_ready = 1'b1;
    push(1'b0, 32'hAAAAAAAA);
    vectors++; if (out0_valid !== 1'b1 || out0_data !== 32'hAAAAAAAA) begin errors++; $display("FAIL route0 got %b/%h exp 1/aaaaaaaa", out0_valid, out0_data); end
    vectors++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL route0_other got %b exp 0", out1_valid); end
    push(1'b1, 32'hBBBBBBBB);
    vectors++; if (out1_valid !== 1'b1 || out1_data !== 32'hBBBBBBBB) begin errors++; $display("FAIL route1 got %b/%h exp 1/bbbbbbbb", out1_valid, out1_data); end
    vectors++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL route1_other got %b exp 0", out0_valid); end
    tick();
    vectors++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL route1_drain got %b exp 0", out1_valid); end
    out0_ready = 1'b0; out1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    push(1'b0, 32'h1);
    push(1'b0, 32'h2);
    vectors++; if (occ0 !== 2'd2) begin errors++; $display("FAIL bp_occ0 got %0d exp 2", occ0); end
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h3; #1;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    in_sel = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_switch_ready got %b exp 1", in_ready); end
    tick(); in_valid = 1'b0;
    vectors++; if (out1_valid !== 1'b1 || out1_data !== 32'h3 || occ1 !== 2'd1) begin errors++; $display("FAIL bp_ch1 got %b/%h/%0d exp 1/00000003/1", out1_valid, out1_data, occ1); end
    vectors++; if (out0_data !== 32'h1 || occ0 !== 2'd2) begin errors++; $display("FAIL bp_ch0_hold got %h/%0d exp 00000001/2", out0_data, occ0); end
    out0_ready = 1'b1; tick();
    vectors++; if (out0_data !== 32'h2 || occ0 !== 2'd1) begin errors++; $display("FAIL bp_drain1 got %h/%0d exp 00000002/1", out0_data, occ0); end
    tick();
    vectors++; if (out0_valid !== 1'b0 || occ0 !== 2'd0) begin errors++; $display("FAIL bp_drain2 got %b/%0d exp 0/0", out0_valid, occ0); end
    out0_ready = 1'b0;
    out1_ready = 1'b1; tick(); out1_ready = 1'b0;
    vectors++; if (occ1 !== 2'd0) begin errors++; $display("FAIL bp_ch1_drain got %0d exp 0", occ1); end
  endtask

  task automatic test_simultaneous();
    push(1'b0, 32'h10);
    vectors++; if (occ0 !== 2'd1 || out0_data !== 32'h10) begin errors++; $display("FAIL sim_pre got %0d/%h exp 1/00000010", occ0, out0_data); end
    out0_ready = 1'b1;
    push(1'b0, 32'h11);
    vectors++; if (occ0 !== 2'd1 || out0_data !== 32'h11) begin errors++; $display("FAIL sim_pushpop got %0d/%h exp 1/00000011", occ0, out0_data); end
    tick();
    out0_ready = 1'b0;
    vectors++; if (occ0 !== 2'd0) begin errors++; $display("FAIL sim_drain got %0d exp 0", occ0); end
  endtask

  task automatic test_wrap();
    logic [N-1:0] q[$];
    logic         pat [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int           idx = 0;
    int           got = 0;
    int           cyc = 0;
    logic         acc;
    logic         pp;
    while (!(idx == 5 && q.size() == 0) && cyc < 40) begin
      in_sel     = 1'b0;
      in_valid   = (idx < 5);
      in_data    = 32'h20 + N'(idx);
      out0_ready = pat[cyc % 10];
      #1;
      acc = in_valid && (q.size() < DEPTH);
      pp  = out0_ready && (q.size() != 0);
      if (idx < 5) begin
        vectors++; if (in_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL wrap_in_ready cyc %0d got %b exp %b", cyc, in_ready, (q.size() < DEPTH)); end
      end
      if (pp) begin
        vectors++; if (out0_data !== q[0]) begin errors++; $display("FAIL wrap_data cyc %0d got %h exp %h", cyc, out0_data, q[0]); end
        void'(q.pop_front());
        got++;
      end
      if (acc) begin
        q.push_back(32'h20 + N'(idx));
        idx++;
      end
      tick();
      vectors++; if (occ0 !== OW'(q.size())) begin errors++; $display("FAIL wrap_occ0 cyc %0d got %0d exp %0d", cyc, occ0, q.size()); end
      cyc++;
    end
    in_valid = 1'b0; out0_ready = 1'b0;
    vectors++; if (got != 5) begin errors++; $display("FAIL wrap_count got %0d exp 5 (cycle budget %0d)", got, cyc); end
  endtask

  task automatic test_full_pop();
    push(1'b1, 32'h40);
    push(1'b1, 32'h41);
    vectors++; if (occ1 !== 2'd2) begin errors++; $display("FAIL fp_occ1 got %0d exp 2", occ1); end
    out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h42; #1;
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fp_ready_full got %b exp 0", in_ready); end
    tick();
    vectors++; if (occ1 !== 2'd1 || out1_data !== 32'h41 || in_ready !== 1'b1) begin errors++; $display("FAIL fp_after_pop got %0d/%h/%b exp 1/00000041/1", occ1, out1_data, in_ready); end
    tick(); in_valid = 1'b0;
    vectors++; if (occ1 !== 2'd1 || out1_data !== 32'h42) begin errors++; $display("FAIL fp_accept got %0d/%h exp 1/00000042", occ1, out1_data); end
    tick();
    vectors++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL fp_drain got %b exp 0", out1_valid); end
    out1_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_simultaneous();
    test_wrap();
    test_full_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/nstream_demux12.md
# nstream_demux12

N-bit 1-to-2 stream demultiplexer with valid/ready handshakes and a per-output FIFO. It sits where one producer stream must be steered to one of two consumers, for example splitting a pipeline result bus between two downstream units. An accepted word is routed by `in_sel`. Output 0 is selected when `in_sel`=0 and output 1 when `in_sel`=1. Each output has independent buffering, so a stalled consumer blocks only its own channel.

## Interface
- `N`, 32, data width in bits
- `DEPTH`, 2, entries per output FIFO; power of two, ≥2
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  N  input word
- `in_sel`  in  1  destination of the current input word (0 → out0, 1 → out1)
- `in_valid`  in  1  producer offers `in_data`/`in_sel`
- `in_ready`  out  1  block can accept the offered word this cycle
- `out0_data`  out  N  head word of FIFO 0
- `out0_valid`  out  1  FIFO 0 non-empty
- `out0_ready`  in  1  consumer 0 takes the head word
- `out1_data`, `out1_valid`, `out1_ready`: same as the channel-0 ports, for FIFO 1
- `occ0`, `occ1`  out  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH

## Operation
- Per channel k: storage array of DEPTH×N, write pointer `wp_k` and read pointer `rp_k` of width $clog2(DEPTH), and occupancy counter `occ_k`.
- `in_ready` = (`in_sel`==0) ? (`occ0`!=DEPTH) : (`occ1`!=DEPTH). This is combinational from `in_sel` and registered state only.
- Push to channel k when `in_valid` && `in_ready` && `in_sel`==k:
  - write `in_data` at `wp_k`;
  - `wp_k` ← `wp_k`+1 mod DEPTH.
- Pop channel k when `outk_valid` && `outk_ready`: `rp_k` ← `rp_k`+1 mod DEPTH.
- Occupancy update per channel:
  - push only: +1
  - pop only: −1
  - both in the same cycle: unchanged
- Simultaneous push and pop on a full FIFO is not allowed. `in_ready` depends only on full, so a pop in the same cycle does not open the channel.
- `outk_valid` = (`occ_k`!=0). `outk_data` = storage[`rp_k`], combinational read of registered storage.
- Per-channel FIFO order is preserved. No ordering relation is guaranteed between channels.
- `outk_ready` asserted while `outk_valid`=0 has no effect. `in_valid`=0 leaves `in_sel` and `in_data` don't-care.
- Producer rule: once `in_valid`=1, `in_valid`, `in_data` and `in_sel` are held until accepted. The block does not check this rule.
- Consumer rule: `outk_data` is stable while `outk_valid`=1 and `outk_ready`=0.

## Timing
- Reset (async assert; deassert synchronous to `clk` by the surrounding design):
  - pointers and `occ0`/`occ1` = 0;
  - storage = 0;
  - `out0_valid`=`out1_valid`=0;
  - `out0_data`=`out1_data`=0;
  - `in_ready`=1 for either `in_sel`.
- Reset mid-operation discards all buffered words immediately, with no clock edge needed.
- Latency: a word accepted at edge t is visible on `outk_data` with `outk_valid`=1 immediately after edge t, i.e. one cycle.
- Throughput: one word per cycle per input. Each channel sustains one word per cycle with `outk_ready` held at 1 and `occ_k` stable at 1.
- Full: with `occ_k`=DEPTH and `in_sel`=k, `in_ready`=0. Changing `in_sel` to the other, non-full channel raises `in_ready` in the same cycle.
- Wrap-around: pointers roll over from DEPTH−1 to 0 with no bubble.

## Test plan
- Reset: drive `rst`=1 mid-stream with words buffered → outputs zero at once, `occ0`=`occ1`=0, `in_ready`=1. After release, the next push appears normally.
- Routing: push 32'hAAAAAAAA with `in_sel`=0, then 32'hBBBBBBBB with `in_sel`=1, both ready high →
  - `out0_data`=AAAAAAAA valid one cycle after its push;
  - `out1_data`=BBBBBBBB valid one cycle after its push;
  - the opposite channel's valid stays 0.
- Backpressure: `out0_ready`=0, push 32'h1, 32'h2 to channel 0 → `occ0`=2 and `in_ready`=0 with `in_sel`=0. Switch `in_sel`=1 → `in_ready`=1 and 32'h3 lands in FIFO 1. Raise `out0_ready` → 1 then 2 drain in order.
- Simultaneous push/pop: `occ0`=1 holding 32'h10, push 32'h11 while popping → `occ0` stays 1, `out0_data`=32'h11 next cycle.
- Wrap-around: stream 32'h20..32'h24 to channel 0, toggling `out0_ready` 1,0,1,1,0… → all five emerge in order, none lost or duplicated, `occ0` never exceeds 2.
- Full with pop: `occ1`=2, `out1_ready`=1, offer a word with `in_sel`=1 → not accepted that cycle (`in_ready`=0), accepted the following cycle.
